// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Main control FSM of the multicycle MIPS core (fetch/decode/exec).
//            Optional bne support is enabled by defining MC_CTRL_BNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [5:0] C_OP_LW   = 6'b100011;
  localparam logic [5:0] C_OP_SW   = 6'b101011;
  localparam logic [5:0] C_OP_RTYP = 6'b000000;
  localparam logic [5:0] C_OP_BEQ  = 6'b000100;
  localparam logic [5:0] C_OP_ADDI = 6'b001000;
  localparam logic [5:0] C_OP_J    = 6'b000010;
  localparam logic [5:0] C_OP_BNE  = 6'b000101;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_cur;
  logic   w_bne;

`ifdef MC_CTRL_BNE_EN
  assign w_bne = (op == C_OP_BNE);
`else
  assign w_bne = 1'b0;
`endif

  // Reset overrides the visible state so outputs show FETCH immediately.
  assign w_cur = rst ? FETCH : r_state;
  assign state = w_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = FETCH;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    retire     = 1'b0;

    case (w_cur)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        w_next    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (op == C_OP_LW || op == C_OP_SW) begin
          w_next = MEMADR;
        end else if (op == C_OP_RTYP) begin
          w_next = EXECUTE;
        end else if (op == C_OP_BEQ || w_bne) begin
          w_next = BRANCH;
        end else if (op == C_OP_ADDI) begin
          w_next = ADDIEXEC;
        end else if (op == C_OP_J) begin
          w_next = JUMP;
        end else begin
          illegal_op = 1'b1;
          retire     = 1'b1;
          w_next     = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (op == C_OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord   = 1'b1;
        w_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        w_next     = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        w_next    = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        w_next    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero ^ w_bne;
        retire    = 1'b1;
        w_next    = FETCH;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        w_next    = FETCH;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
        w_next = FETCH;
      end
      default: begin
        w_next = FETCH;
      end
    endcase

    // Reset kills every side effect, including a pending MEMWR write.
    if (rst) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Randomized instruction stream checked against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op, retire;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .retire     (retire),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010) ||
           (BNE_EN && o == 6'b000101);
  endfunction

  // Expected output word for a given state, straight from the per-state table.
  function automatic logic [15:0] ref_out(input int st, input bit mr, input bit z,
                                          input logic [5:0] o);
    bit pce = 0, io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
    bit ill = 0, ret = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, ps = 2'b00;
    case (st)
      0:  begin asb = 2'b01; irw = mr; pce = mr; end
      1:  begin asb = 2'b11; if (!legal(o)) begin ill = 1; ret = 1; end end
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin io = 1; mw = 1; ret = mr; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; ps = 2'b01; ret = 1;
                pce = z ^ (BNE_EN && o == 6'b000101); end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; ret = 1; end
      11: begin ps = 2'b10; pce = 1; ret = 1; end
      default: ;
    endcase
    return {pce, io, mw, irw, rd, m2r, rw, asa, asb, aop, ps, ill, ret};
  endfunction

  function automatic logic [15:0] dut_out();
    return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, retire};
  endfunction

  initial begin
    int path[$];
    bit mrq[$];
    logic [5:0] o;
    bit z;
    int kind, fw, mw, base, nret, last;

    // Reset held for 3 cycles with mem_ready high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1;
      #1;
      check("rst_state", state, 0);
      check("rst_strobes", {pc_en, ir_write, reg_write, mem_write, illegal_op, retire}, 0);
      check("rst_alu_src_b", alu_src_b, 2'b01);
    end

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 7);
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 2);
      z    = 1'($urandom_range(0, 1));
      path.delete(); mrq.delete();
      case (kind)
        0: begin o = 6'b100011; base = 5; end
        1: begin o = 6'b101011; base = 4; end
        2: begin o = 6'b000000; base = 4; mw = 0; end
        3: begin o = 6'b000100; base = 3; mw = 0; end
        4: begin o = 6'b001000; base = 4; mw = 0; end
        5: begin o = 6'b000010; base = 3; mw = 0; end
        6: begin o = 6'b000101; base = BNE_EN ? 3 : 2; mw = 0; end
        default: begin
          do o = 6'($urandom_range(0, 63)); while (legal(o));
          base = 2; mw = 0;
        end
      endcase
      if (n == 0) fw = 0;
      for (int i = 0; i < fw; i++) begin path.push_back(0); mrq.push_back(0); end
      path.push_back(0); mrq.push_back(1);
      path.push_back(1); mrq.push_back(1'($urandom_range(0, 1)));
      case (kind)
        0: begin
          path.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < mw; i++) begin path.push_back(3); mrq.push_back(0); end
          path.push_back(3); mrq.push_back(1);
          path.push_back(4); mrq.push_back(1'($urandom_range(0, 1)));
        end
        1: begin
          path.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
          for (int i = 0; i < mw; i++) begin path.push_back(5); mrq.push_back(0); end
          path.push_back(5); mrq.push_back(1);
        end
        2: begin path.push_back(6); path.push_back(7); end
        3: path.push_back(8);
        4: begin path.push_back(9); path.push_back(10); end
        5: path.push_back(11);
        6: if (BNE_EN) path.push_back(8);
        default: ;
      endcase
      while (mrq.size() < path.size()) mrq.push_back(1'($urandom_range(0, 1)));

      nret = 0; last = -1;
      for (int i = 0; i < path.size(); i++) begin
        @(negedge clk);
        rst = 1'b0; mem_ready = mrq[i]; zero = z; op = o;
        #1;
        check("state", state, path[i]);
        check("outputs", dut_out(), ref_out(path[i], mrq[i], z, o));
        if (retire) begin nret++; last = i; end
      end
      check("retire_count", nret, 1);
      check("instr_cycles", last + 1, base + fw + mw);
    end

    // sw stalled in MEMWR, then aborted by reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0; op = 6'b101011; mem_ready = (i < 3);
      #1;
    end
    check("memwr_state", state, 5);
    check("memwr_write", mem_write, 1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check("abort_write", mem_write, 0);
    check("abort_retire", retire, 0);
    check("abort_state", state, 0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("post_abort_state", state, 0);
    check("post_abort_strobes", {mem_write, retire, ir_write}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
